// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if: requester-side handshake and result bus of the shared multiplier.
interface mult_share_arb_if #(parameter int SIZE = 8);
    logic              req0;
    logic [SIZE-1:0]   a0;
    logic [SIZE-1:0]   b0;
    logic              gnt0;
    logic              req1;
    logic [SIZE-1:0]   a1;
    logic [SIZE-1:0]   b1;
    logic              gnt1;
    logic [2*SIZE-1:0] out;
    logic              out_valid;
    logic              out_id;
    logic              busy;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, out, out_valid, out_id, busy
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, out, out_valid, out_id, busy
    );
endinterface

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin shares one SIZE x SIZE multiplier between two requesters.
module mult_share_arb #(
    parameter int SIZE = 8
) (
    input logic              clk,
    input logic              reset,
    mult_share_arb_if.slave  bus
);
    typedef enum logic {IDLE, MUL} state_t;

    state_t          state;
    logic [SIZE-1:0] opa;
    logic [SIZE-1:0] opb;
    logic            id;
    logic            last;
    logic            pick1;

    // On contention the requester that was not served last wins.
    assign pick1 = bus.req1 & (~bus.req0 | ~last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            opa           <= '0;
            opb           <= '0;
            id            <= 1'b0;
            last          <= 1'b1;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_id    <= 1'b0;
            bus.busy      <= 1'b0;
        end else if (state == IDLE) begin
            bus.gnt0      <= bus.req0 & ~pick1;
            bus.gnt1      <= pick1;
            bus.out_valid <= 1'b0;
            if (bus.req0 | bus.req1) begin
                opa      <= pick1 ? bus.a1 : bus.a0;
                opb      <= pick1 ? bus.b1 : bus.b0;
                id       <= pick1;
                last     <= pick1;
                bus.busy <= 1'b1;
                state    <= MUL;
            end
        end else begin
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.out       <= {{SIZE{1'b0}}, opa} * {{SIZE{1'b0}}, opb};
            bus.out_id    <= id;
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
        end
    end
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: directed table, fairness, reset-abort and random sweep checks.
module tb_mult_share_arb;
    typedef struct {
        logic        r0;
        logic        r1;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic [7:0]  a1;
        logic [7:0]  b1;
        logic        g0;
        logic        g1;
        logic [15:0] p;
        logic        id;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic last_m;
    vec_t tbl[8];

    mult_share_arb_if #(.SIZE(8)) bus();
    mult_share_arb #(.SIZE(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic txn(input vec_t v, input string name);
        @(negedge clk);
        bus.req0 = v.r0; bus.req1 = v.r1;
        bus.a0 = v.a0; bus.b0 = v.b0; bus.a1 = v.a1; bus.b1 = v.b1;
        @(posedge clk); #1;
        chk({name, ".gnt"}, {30'd0, bus.gnt1, bus.gnt0}, {30'd0, v.g1, v.g0});
        chk({name, ".busy1"}, {31'd0, bus.busy}, 32'd1);
        chk({name, ".nov"}, {31'd0, bus.out_valid}, 32'd0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = ~bus.a0; bus.b0 = bus.b0 + 8'd37; bus.a1 = ~bus.a1; bus.b1 = bus.b1 + 8'd91;
        @(posedge clk); #1;
        chk({name, ".out"}, {16'd0, bus.out}, {16'd0, v.p});
        chk({name, ".id"}, {31'd0, bus.out_id}, {31'd0, v.id});
        chk({name, ".ov"}, {29'd0, bus.out_valid, bus.busy, bus.gnt0 | bus.gnt1}, 32'd4);
    endtask

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
        tbl[0] = '{1'b1, 1'b1, 8'd7,   8'd9,   8'd12,  8'd11,  1'b1, 1'b0, 16'd63,    1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'd7,   8'd9,   8'd12,  8'd11,  1'b0, 1'b1, 16'd132,   1'b1};
        tbl[2] = '{1'b1, 1'b0, 8'd3,   8'd5,   8'd0,   8'd0,   1'b1, 1'b0, 16'd15,    1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'd1,   8'd1,   8'd255, 8'd255, 1'b0, 1'b1, 16'd65025, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 8'd0,   8'd200, 8'd9,   8'd9,   1'b1, 1'b0, 16'd0,     1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'd255, 8'd1,   8'd16,  8'd16,  1'b0, 1'b1, 16'd256,   1'b1};
        tbl[6] = '{1'b1, 1'b1, 8'd100, 8'd200, 8'd2,   8'd3,   1'b1, 1'b0, 16'd20000, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'd4,   8'd4,   8'd1,   8'd255, 1'b0, 1'b1, 16'd255,   1'b1};
        #1;
        chk("reset.outs", {11'd0, bus.gnt0, bus.gnt1, bus.out_valid, bus.busy, bus.out_id, bus.out}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) txn(tbl[i], $sformatf("vec%0d", i));

        // Both held: grants alternate starting with requester 0 (requester 1 went last).
        last_m = 1'b1;
        @(negedge clk);
        bus.req0 = 1; bus.req1 = 1; bus.a0 = 5; bus.b0 = 6; bus.a1 = 7; bus.b1 = 8;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("fair.gnt", {30'd0, bus.gnt1, bus.gnt0}, {30'd0, ~last_m, last_m});
            chk("fair.gnt_ov", {31'd0, bus.out_valid}, 32'd0);
            last_m = ~last_m;
            @(posedge clk); #1;
            chk("fair.out", {15'd0, bus.out_id, bus.out}, last_m ? {15'd1, 16'd56} : {15'd0, 16'd30});
            chk("fair.res_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        end
        @(negedge clk);
        bus.req0 = 0; bus.req1 = 0;

        // Reset in the MUL cycle aborts the product.
        @(negedge clk);
        bus.req0 = 1; bus.a0 = 3; bus.b0 = 4;
        @(posedge clk); #1;
        chk("abort.gnt0", {30'd0, bus.busy, bus.gnt0}, 32'd3);
        bus.req0 = 0;
        #1 reset = 1'b1;
        #1;
        chk("abort.outs", {11'd0, bus.gnt0, bus.gnt1, bus.out_valid, bus.busy, bus.out_id, bus.out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort.nov", {15'd0, bus.out_valid, bus.out}, 32'd0);
        txn('{1'b0, 1'b1, 8'd0, 8'd0, 8'd9, 8'd9, 1'b0, 1'b1, 16'd81, 1'b1}, "after_reset");

        last_m = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            vec_t v;
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            v.r0 = r[0]; v.r1 = r[1];
            v.a0 = 8'($urandom); v.b0 = 8'($urandom); v.a1 = 8'($urandom); v.b1 = 8'($urandom);
            v.g1 = v.r1 & (~v.r0 | ~last_m);
            v.g0 = ~v.g1;
            v.id = v.g1;
            v.p = v.g1 ? 16'(v.a1) * 16'(v.b1) : 16'(v.a0) * 16'(v.b0);
            last_m = v.g1;
            txn(v, "sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
